mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// - Shares the single memory port between instruction fetch (imem side) and the execute-stage load/store path (dmem side).
// - Sits between fetch/execute and the memory subsystem. Execute stalls on dmem_ready low; fetch stalls on imem_ready low.
// - Data side has fixed priority. A starvation counter bounds instruction-side wait.
// - Holds at most one outstanding memory transaction.
// PARAMETERS
// - STARVE_MAX  4  consecutive data grants taken while imem_valid waits before the next grant is forced to imem (1..15)
// PORTS
// - clock       in   1   single clock; all state updates on posedge
// - reset       in   1   synchronous, active-high
// - imem_valid  in   1   fetch request; held with imem_addr stable until imem_ready
// - imem_addr   in   32  fetch address
// - imem_ready  out  1   one-cycle pulse: fetch complete, imem_rdata valid
// - imem_rdata  out  32  fetch data
// - iflush      in   1   kill any in-flight fetch (trap/mret/branch redirect)
// - dmem_valid  in   1   load/store request; held with fields stable until dmem_ready
// - dmem_addr   in   32  data address
// - dmem_wdata  in   32  store data
// - dmem_wstrb  in   4   byte strobes; 0 = load
// - dmem_ready  out  1   one-cycle pulse: access complete, dmem_rdata valid
// - dmem_rdata  out  32  load data
// - mem_valid   out  1   request to memory; level, held through the mem_ready cycle
// - mem_instr   out  1   1 = instruction fetch owns the port
// - mem_addr    out  32  registered address
// - mem_wdata   out  32  registered store data
// - mem_wstrb   out  4   registered strobes; 0 for fetches
// - mem_rdata   in   32  memory read data
// - mem_ready   in   1   memory completion pulse
// BEHAVIOUR
// - States:
//   - IDLE: no outstanding access.
//   - IBUSY: fetch outstanding.
//   - DBUSY: data access outstanding.
// - Reset:
//   - state = IDLE, kill = 0, starve = 0.
//   - mem_valid, mem_instr, imem_ready and dmem_ready = 0.
//   - mem_addr, mem_wdata and mem_wstrb = 0.
// - Arbitration: evaluated in IDLE, or in a BUSY cycle that has mem_ready = 1.
//   - The current owner's request is excluded in its own ready cycle, because the requester still shows valid.
//   - Winner: imem if imem_valid and starve == STARVE_MAX; else dmem if dmem_valid; else imem if imem_valid; else IDLE.
// - Issue:
//   - Winner fields are registered. mem_valid = 1 starting the next cycle.
//   - Request-to-mem_valid latency is 1 cycle.
//   - Back-to-back transactions have no idle cycle between them.
// - Completion in the mem_ready cycle, combinational forwarding:
//   - imem_rdata = dmem_rdata = mem_rdata.
//   - Owner's ready pulses for 1 cycle.
//   - mem_valid drops next cycle unless a new grant is issued.
// - Starvation counter:
//   - starve increments, saturating at STARVE_MAX, on each dmem grant while imem_valid = 1.
//   - starve clears on any imem grant, and when imem_valid = 0 in IDLE.
// - iflush:
//   - If iflush = 1 in IBUSY, or in the cycle imem is granted, set kill.
//   - The in-flight fetch still completes on the memory side, but its imem_ready is suppressed.
//   - kill clears on that mem_ready.
//   - iflush in the mem_ready cycle of a fetch also suppresses imem_ready.
//   - iflush never affects a dmem access.
// - mem_ready in IDLE (stale, e.g. after a reset mid-access) is ignored; nothing is forwarded.
// - Reset mid-operation: the outstanding access is abandoned and requesters must re-request.
// - Simultaneous imem_valid and dmem_valid in IDLE with starve < STARVE_MAX: dmem wins.
// STRUCTURE
// - constants package: arb_state_type enum (IDLE, IBUSY, DBUSY); STARVE_W = 4; init_mem_arb_reg.
// - wires package: mem_arb_reg_type (state, kill, starve, addr, wdata, wstrb, instr).
// - Reuse existing mem_in_type/mem_out_type for the port bundles.
// - Single always_comb (v = r) plus always_ff register. No sub-module; the counter and FSM are too small to split.
// TESTING
// 1. Reset, then imem_valid addr=0x100. Expect mem_valid next cycle with mem_instr = 1. mem_ready with rdata = 0xDEADBEEF -> imem_ready pulse, imem_rdata = 0xDEADBEEF.
// 2. imem_valid and dmem_valid rise together in IDLE. Expect dmem granted first, then imem issued the cycle after dmem's mem_ready (no idle gap).
// 3. dmem_valid held continuously, imem_valid waiting, STARVE_MAX = 4. Expect exactly 4 data grants, then a forced imem grant, then starve = 0.
// 4. Fetch issued, iflush pulsed in IBUSY. Then mem_ready arrives -> no imem_ready. A following dmem store (wstrb = 0xF) completes normally.
// 5. Reset asserted during DBUSY; memory returns mem_ready after reset deasserts -> no dmem_ready or imem_ready, state stays IDLE.
// 6. Store wstrb = 0x3, data = 0x1234 -> mem_wstrb = 0x3 and mem_wdata = 0x1234 stable through the mem_ready cycle; dmem_ready pulses exactly once.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory-port arbiter.
//   arb_state_type   : port ownership state (IDLE / IBUSY / DBUSY)
//   mem_arb_reg_type : complete registered state of the arbiter
//   init_mem_arb_reg : reset value of mem_arb_reg_type
package mem_port_arbiter_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned STRB_W   = 4;
    localparam int unsigned STARVE_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2
    } arb_state_type;

    typedef struct packed {
        arb_state_type         state;
        logic                  kill;
        logic [STARVE_W-1:0]   starve;
        logic [XLEN-1:0]       addr;
        logic [XLEN-1:0]       wdata;
        logic [STRB_W-1:0]     wstrb;
        logic                  instr;
    } mem_arb_reg_type;

    localparam mem_arb_reg_type init_mem_arb_reg = '{
        state  : IDLE,
        kill   : 1'b0,
        starve : '0,
        addr   : '0,
        wdata  : '0,
        wstrb  : '0,
        instr  : 1'b0
    };

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (imem) and load/store (dmem).
// Data side has fixed priority; a saturating starvation counter forces an
// instruction grant after STARVE_MAX data grants taken while a fetch waits.
// At most one transaction is outstanding.
// Ports:
//   clock, reset                 : clock, synchronous active-high reset
//   imem_valid/addr              : fetch request (held until imem_ready)
//   imem_ready/rdata             : fetch completion pulse and data
//   iflush                       : kill any in-flight fetch
//   dmem_valid/addr/wdata/wstrb  : load/store request (wstrb = 0 is a load)
//   dmem_ready/rdata             : data completion pulse and data
//   mem_valid/instr/addr/wdata/wstrb : registered request to memory
//   mem_rdata/mem_ready          : memory read data and completion pulse
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              imem_valid,
    input  logic [XLEN-1:0]   imem_addr,
    output logic              imem_ready,
    output logic [XLEN-1:0]   imem_rdata,
    input  logic              iflush,
    input  logic              dmem_valid,
    input  logic [XLEN-1:0]   dmem_addr,
    input  logic [XLEN-1:0]   dmem_wdata,
    input  logic [STRB_W-1:0] dmem_wstrb,
    output logic              dmem_ready,
    output logic [XLEN-1:0]   dmem_rdata,
    output logic              mem_valid,
    output logic              mem_instr,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [STRB_W-1:0] mem_wstrb,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_ready
);

    mem_arb_reg_type r, v;

    logic busy;
    logic arb;
    logic req_i;
    logic req_d;
    logic starve_full;
    logic grant_i;
    logic grant_d;

    // Next-state, arbitration and completion forwarding
    always_comb begin
        v          = r;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        imem_rdata = mem_rdata;
        dmem_rdata = mem_rdata;
        grant_i    = 1'b0;
        grant_d    = 1'b0;

        busy        = (r.state != IDLE);
        // mem_ready seen in IDLE is stale and must not trigger anything
        arb         = !busy || mem_ready;
        // The owner still shows valid in its own ready cycle; do not re-grant it
        req_i       = imem_valid && (r.state != IBUSY);
        req_d       = dmem_valid && (r.state != DBUSY);
        starve_full = (r.starve >= STARVE_W'(STARVE_MAX));

        if (arb) begin
            if (req_i && starve_full) begin
                grant_i = 1'b1;
            end else if (req_d) begin
                grant_d = 1'b1;
            end else if (req_i) begin
                grant_i = 1'b1;
            end
        end

        // Completion of the outstanding access
        if (busy && mem_ready) begin
            if (r.state == IBUSY) begin
                imem_ready = !r.kill && !iflush;
            end else begin
                dmem_ready = 1'b1;
            end
            v.state = IDLE;
            v.kill  = 1'b0;
            v.instr = 1'b0;
        end

        // Flush while a fetch is in flight: the memory side finishes, the pulse is dropped
        if ((r.state == IBUSY) && !mem_ready && iflush) begin
            v.kill = 1'b1;
        end

        if ((r.state == IDLE) && !imem_valid) begin
            v.starve = '0;
        end

        if (grant_i) begin
            v.state  = IBUSY;
            v.instr  = 1'b1;
            v.addr   = imem_addr;
            v.wdata  = '0;
            v.wstrb  = '0;
            v.starve = '0;
            v.kill   = iflush;
        end else if (grant_d) begin
            v.state = DBUSY;
            v.instr = 1'b0;
            v.addr  = dmem_addr;
            v.wdata = dmem_wdata;
            v.wstrb = dmem_wstrb;
            v.kill  = 1'b0;
            if (req_i && !starve_full) begin
                v.starve = r.starve + STARVE_W'(1);
            end
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r <= init_mem_arb_reg;
        end else begin
            r <= v;
        end
    end

    assign mem_valid = (r.state != IDLE);
    assign mem_instr = r.instr;
    assign mem_addr  = r.addr;
    assign mem_wdata = r.wdata;
    assign mem_wstrb = r.wstrb;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_valid;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        iflush;
    logic        dmem_valid;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int n_cmp = 0;
    int n_bad = 0;

    mem_port_arbiter #(.STARVE_MAX(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .imem_valid (imem_valid),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .iflush     (iflush),
        .dmem_valid (dmem_valid),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_wstrb (dmem_wstrb),
        .dmem_ready (dmem_ready),
        .dmem_rdata (dmem_rdata),
        .mem_valid  (mem_valid),
        .mem_instr  (mem_instr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        is_data;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        logic        exp_instr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_wstrb;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One isolated transaction from IDLE with a single memory wait cycle
    task automatic apply_vec(input int i);
        vec_t  t;
        string nm;
        t  = vecs[i];
        nm = $sformatf("vec%0d", i);
        imem_valid = !t.is_data;
        imem_addr  = t.addr;
        dmem_valid = t.is_data;
        dmem_addr  = t.addr;
        dmem_wdata = t.wdata;
        dmem_wstrb = t.wstrb;
        #1;
        chk({nm, ".latency"}, 32'(mem_valid), 32'd0);
        tick();
        chk({nm, ".mem_valid"}, 32'(mem_valid), 32'd1);
        chk({nm, ".mem_instr"}, 32'(mem_instr), 32'(t.exp_instr));
        chk({nm, ".mem_addr"}, mem_addr, t.addr);
        if (t.is_data) chk({nm, ".mem_wdata"}, mem_wdata, t.exp_wdata);
        chk({nm, ".mem_wstrb"}, 32'(mem_wstrb), 32'(t.exp_wstrb));
        tick();
        chk({nm, ".wait_valid"}, 32'(mem_valid), 32'd1);
        chk({nm, ".wait_ready"}, 32'({imem_ready, dmem_ready}), 32'd0);
        mem_ready = 1'b1;
        mem_rdata = t.rdata;
        #1;
        chk({nm, ".imem_ready"}, 32'(imem_ready), 32'(!t.is_data));
        chk({nm, ".dmem_ready"}, 32'(dmem_ready), 32'(t.is_data));
        if (t.is_data) chk({nm, ".dmem_rdata"}, dmem_rdata, t.rdata);
        else           chk({nm, ".imem_rdata"}, imem_rdata, t.rdata);
        chk({nm, ".ready_valid"}, 32'(mem_valid), 32'd1);
        chk({nm, ".ready_wstrb"}, 32'(mem_wstrb), 32'(t.exp_wstrb));
        if (t.is_data) chk({nm, ".ready_wdata"}, mem_wdata, t.exp_wdata);
        tick();
        imem_valid = 1'b0;
        dmem_valid = 1'b0;
        mem_ready  = 1'b0;
        #1;
        chk({nm, ".drop_valid"}, 32'(mem_valid), 32'd0);
        chk({nm, ".single_pulse"}, 32'({imem_ready, dmem_ready}), 32'd0);
    endtask

    // Fetch waits through data grants; fetch withdraws in each data ready
    // cycle so the port returns to IDLE and both request again there.
    task automatic starve_phase(input int ph);
        for (int k = 0; k < 5; k++) begin
            imem_valid = 1'b1;
            imem_addr  = 32'h400;
            dmem_valid = 1'b1;
            dmem_addr  = 32'h500 + 32'(4 * k);
            dmem_wstrb = 4'h0;
            tick();
            chk($sformatf("starve%0d.r%0d.valid", ph, k), 32'(mem_valid), 32'd1);
            chk($sformatf("starve%0d.r%0d.instr", ph, k), 32'(mem_instr), 32'(k == 4));
            mem_ready = 1'b1;
            mem_rdata = 32'hA000_0000 + 32'(k);
            if (k < 4) begin
                imem_valid = 1'b0;
                #1;
                chk($sformatf("starve%0d.r%0d.dmem_ready", ph, k), 32'(dmem_ready), 32'd1);
            end else begin
                dmem_valid = 1'b0;
                #1;
                chk($sformatf("starve%0d.forced_imem_ready", ph), 32'(imem_ready), 32'd1);
            end
            tick();
            mem_ready  = 1'b0;
            dmem_valid = 1'b0;
            imem_valid = 1'b0;
            #1;
            chk($sformatf("starve%0d.r%0d.idle", ph, k), 32'(mem_valid), 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{is_data:1'b0, addr:32'h0000_0100, wdata:32'h0, wstrb:4'h0, rdata:32'hDEAD_BEEF,
                    exp_instr:1'b1, exp_wdata:32'h0, exp_wstrb:4'h0};
        vecs[1] = '{is_data:1'b1, addr:32'h0000_2000, wdata:32'h0000_0055, wstrb:4'h0, rdata:32'hCAFE_F00D,
                    exp_instr:1'b0, exp_wdata:32'h0000_0055, exp_wstrb:4'h0};
        vecs[2] = '{is_data:1'b1, addr:32'h0000_3004, wdata:32'h0000_1234, wstrb:4'h3, rdata:32'h0,
                    exp_instr:1'b0, exp_wdata:32'h0000_1234, exp_wstrb:4'h3};
        vecs[3] = '{is_data:1'b0, addr:32'h0000_0104, wdata:32'h0, wstrb:4'h0, rdata:32'h0000_0013,
                    exp_instr:1'b1, exp_wdata:32'h0, exp_wstrb:4'h0};
        vecs[4] = '{is_data:1'b1, addr:32'h0000_3008, wdata:32'hA5A5_A5A5, wstrb:4'hF, rdata:32'h0,
                    exp_instr:1'b0, exp_wdata:32'hA5A5_A5A5, exp_wstrb:4'hF};

        reset      = 1'b1;
        imem_valid = 1'b0;
        imem_addr  = 32'h0;
        iflush     = 1'b0;
        dmem_valid = 1'b0;
        dmem_addr  = 32'h0;
        dmem_wdata = 32'h0;
        dmem_wstrb = 4'h0;
        mem_rdata  = 32'h0;
        mem_ready  = 1'b0;
        tick();
        tick();
        chk("reset.mem_valid", 32'(mem_valid), 32'd0);
        chk("reset.mem_instr", 32'(mem_instr), 32'd0);
        chk("reset.mem_addr", mem_addr, 32'd0);
        chk("reset.mem_wdata", mem_wdata, 32'd0);
        chk("reset.mem_wstrb", 32'(mem_wstrb), 32'd0);
        chk("reset.readies", 32'({imem_ready, dmem_ready}), 32'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) apply_vec(i);

        // Simultaneous requests: data first, fetch issued with no idle gap
        imem_valid = 1'b1;
        imem_addr  = 32'h200;
        dmem_valid = 1'b1;
        dmem_addr  = 32'h300;
        dmem_wstrb = 4'h0;
        tick();
        chk("both.first_instr", 32'(mem_instr), 32'd0);
        chk("both.first_addr", mem_addr, 32'h300);
        mem_ready = 1'b1;
        mem_rdata = 32'h11;
        #1;
        chk("both.dmem_ready", 32'(dmem_ready), 32'd1);
        chk("both.no_imem_ready", 32'(imem_ready), 32'd0);
        tick();
        dmem_valid = 1'b0;
        mem_ready  = 1'b0;
        #1;
        chk("both.b2b_valid", 32'(mem_valid), 32'd1);
        chk("both.b2b_instr", 32'(mem_instr), 32'd1);
        chk("both.b2b_addr", mem_addr, 32'h200);
        mem_ready = 1'b1;
        mem_rdata = 32'h22;
        #1;
        chk("both.imem_ready", 32'(imem_ready), 32'd1);
        chk("both.imem_rdata", imem_rdata, 32'h22);
        tick();
        imem_valid = 1'b0;
        mem_ready  = 1'b0;
        #1;
        chk("both.idle", 32'(mem_valid), 32'd0);

        // Starvation bound, twice to show the counter restarts from zero
        starve_phase(0);
        starve_phase(1);

        // iflush in IBUSY suppresses the fetch; following store unaffected
        imem_valid = 1'b1;
        imem_addr  = 32'h600;
        tick();
        chk("flush.issue_instr", 32'(mem_instr), 32'd1);
        iflush = 1'b1;
        tick();
        iflush     = 1'b0;
        mem_ready  = 1'b1;
        mem_rdata  = 32'h77;
        dmem_valid = 1'b1;
        dmem_addr  = 32'h700;
        dmem_wdata = 32'hF00D_F00D;
        dmem_wstrb = 4'hF;
        #1;
        chk("flush.imem_ready_killed", 32'(imem_ready), 32'd0);
        chk("flush.valid_in_ready", 32'(mem_valid), 32'd1);
        tick();
        imem_valid = 1'b0;
        mem_ready  = 1'b0;
        #1;
        chk("flush.store_instr", 32'(mem_instr), 32'd0);
        chk("flush.store_wstrb", 32'(mem_wstrb), 32'hF);
        chk("flush.store_wdata", mem_wdata, 32'hF00D_F00D);
        mem_ready = 1'b1;
        iflush    = 1'b1;
        #1;
        chk("flush.store_dmem_ready", 32'(dmem_ready), 32'd1);
        chk("flush.store_no_imem", 32'(imem_ready), 32'd0);
        tick();
        iflush     = 1'b0;
        dmem_valid = 1'b0;
        mem_ready  = 1'b0;

        // iflush in the fetch ready cycle; next fetch then completes normally
        imem_valid = 1'b1;
        imem_addr  = 32'h800;
        tick();
        mem_ready = 1'b1;
        iflush    = 1'b1;
        #1;
        chk("flush_rdy.imem_ready", 32'(imem_ready), 32'd0);
        tick();
        iflush    = 1'b0;
        mem_ready = 1'b0;
        imem_addr = 32'h804;
        #1;
        chk("flush_rdy.idle", 32'(mem_valid), 32'd0);
        tick();
        chk("flush_rdy.refetch_addr", mem_addr, 32'h804);
        mem_ready = 1'b1;
        #1;
        chk("flush_rdy.refetch_ready", 32'(imem_ready), 32'd1);
        tick();
        imem_valid = 1'b0;
        mem_ready  = 1'b0;

        // Reset during DBUSY, stale mem_ready afterwards is ignored
        dmem_valid = 1'b1;
        dmem_addr  = 32'h900;
        dmem_wstrb = 4'h0;
        tick();
        chk("rstmid.busy", 32'(mem_valid), 32'd1);
        reset = 1'b1;
        tick();
        reset      = 1'b0;
        dmem_valid = 1'b0;
        #1;
        chk("rstmid.abandoned", 32'(mem_valid), 32'd0);
        tick();
        mem_ready = 1'b1;
        mem_rdata = 32'h99;
        #1;
        chk("rstmid.stale_ready", 32'({imem_ready, dmem_ready}), 32'd0);
        tick();
        mem_ready = 1'b0;
        #1;
        chk("rstmid.still_idle", 32'(mem_valid), 32'd0);
        chk("rstmid.addr_cleared", mem_addr, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
